// File: rtl/mvp_arbiter.sv
// Two-requester arbiter in front of a single 4x4 matrix-vector unit, one job in flight.
// Optional issue-to-result watchdog enabled by defining MVP_ARB_TIMEOUT_EN.
module mvp_arbiter #(
  parameter int unsigned W       = 32,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            r0_valid,
  output logic            r0_ready,
  input  logic [16*W-1:0] r0_mat,
  input  logic [4*W-1:0]  r0_vec,
  output logic [4*W-1:0]  r0_res,
  output logic            r0_res_valid,
  input  logic            r0_res_ready,
  input  logic            r1_valid,
  output logic            r1_ready,
  input  logic [16*W-1:0] r1_mat,
  input  logic [4*W-1:0]  r1_vec,
  output logic [4*W-1:0]  r1_res,
  output logic            r1_res_valid,
  input  logic            r1_res_ready,
  output logic            mv_i_valid,
  input  logic            mv_i_ready,
  output logic [16*W-1:0] mv_mat,
  output logic [4*W-1:0]  mv_vec,
  input  logic [4*W-1:0]  mv_prod,
  input  logic            mv_o_valid,
  output logic            mv_o_ready,
  output logic            owner,
  output logic            busy,
  output logic [7:0]      jobs0,
  output logic [7:0]      jobs1,
  output logic            timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RETURN} state_t;

  state_t            state_q;
  logic              ptr_q;
  logic              owner_q;
  logic [16*W-1:0]   mat_q;
  logic [4*W-1:0]    vec_q;
  logic [4*W-1:0]    res_q;
  logic [7:0]        jobs0_q;
  logic [7:0]        jobs1_q;
  logic              pick_c;
  logic              accept_c;
  logic              res_taken_c;
  logic              timeout_hit_c;

  if (TIMEOUT == 0) begin : g_timeout_chk
    $error("mvp_arbiter: TIMEOUT must be non-zero");
  end

  // Lone requester wins outright; on contention the pointer decides.
  always_comb begin
    pick_c = ptr_q;
    if (!(r0_valid && r1_valid)) pick_c = r1_valid;
  end

  assign accept_c    = (state_q == IDLE) && !rst && (r0_valid || r1_valid);
  assign r0_ready    = accept_c && !pick_c;
  assign r1_ready    = accept_c && pick_c;
  assign res_taken_c = owner_q ? r1_res_ready : r0_res_ready;

  assign mv_i_valid   = (state_q == ISSUE);
  assign mv_o_ready   = (state_q == WAIT);
  assign mv_mat       = mat_q;
  assign mv_vec       = vec_q;
  assign r0_res       = res_q;
  assign r1_res       = res_q;
  assign r0_res_valid = (state_q == RETURN) && !owner_q;
  assign r1_res_valid = (state_q == RETURN) && owner_q;
  assign owner        = owner_q;
  assign busy         = (state_q != IDLE);
  assign jobs0        = jobs0_q;
  assign jobs1        = jobs1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      mat_q   <= '0;
      vec_q   <= '0;
      res_q   <= '0;
      jobs0_q <= 8'd0;
      jobs1_q <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            mat_q   <= pick_c ? r1_mat : r0_mat;
            vec_q   <= pick_c ? r1_vec : r0_vec;
            owner_q <= pick_c;
            ptr_q   <= ~pick_c;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (timeout_hit_c)   state_q <= IDLE;
          else if (mv_i_ready) state_q <= WAIT;
        end
        WAIT: begin
          if (mv_o_valid) begin
            res_q   <= mv_prod;
            state_q <= RETURN;
          end else if (timeout_hit_c) begin
            state_q <= IDLE;
          end
        end
        RETURN: begin
          if (res_taken_c) begin
            if (owner_q) jobs1_q <= jobs1_q + 8'd1;
            else         jobs0_q <= jobs0_q + 8'd1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MVP_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic          err_q;

  // A response arriving on the last allowed cycle still wins over the timeout.
  assign timeout_hit_c = (cnt_q == CW'(TIMEOUT - 1)) &&
                         ((state_q == ISSUE) || ((state_q == WAIT) && !mv_o_valid));
  assign timeout_err   = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (accept_c) cnt_q <= '0;
      else if ((state_q == ISSUE) || (state_q == WAIT)) cnt_q <= cnt_q + CW'(1);
      if (timeout_hit_c) err_q <= 1'b1;
    end
  end
`else
  assign timeout_hit_c = 1'b0;
  assign timeout_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mvp_arbiter.sv
// Scoreboard bench for mvp_arbiter: behavioural matrix-vector unit plus per-requester result queues.
module tb_mvp_arbiter;
  localparam int unsigned W  = 32;
  localparam int unsigned TO = 16;

  logic            clk, rst;
  logic            r0_valid, r0_ready, r0_res_valid, r0_res_ready;
  logic            r1_valid, r1_ready, r1_res_valid, r1_res_ready;
  logic [16*W-1:0] r0_mat, r1_mat, mv_mat;
  logic [4*W-1:0]  r0_vec, r1_vec, mv_vec, r0_res, r1_res, mv_prod;
  logic            mv_i_valid, mv_i_ready, mv_o_valid, mv_o_ready;
  logic            owner, busy, timeout_err;
  logic [7:0]      jobs0, jobs1;

  int errors = 0;
  int checks = 0;
  logic [4*W-1:0] exp0[$];
  logic [4*W-1:0] exp1[$];
  int acc_q[$];
  int u_stall = 0;
  int u_lat = 3;
  bit u_silent = 0;

  mvp_arbiter #(.W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_mat(r0_mat), .r0_vec(r0_vec),
    .r0_res(r0_res), .r0_res_valid(r0_res_valid), .r0_res_ready(r0_res_ready),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_mat(r1_mat), .r1_vec(r1_vec),
    .r1_res(r1_res), .r1_res_valid(r1_res_valid), .r1_res_ready(r1_res_ready),
    .mv_i_valid(mv_i_valid), .mv_i_ready(mv_i_ready), .mv_mat(mv_mat), .mv_vec(mv_vec),
    .mv_prod(mv_prod), .mv_o_valid(mv_o_valid), .mv_o_ready(mv_o_ready),
    .owner(owner), .busy(busy), .jobs0(jobs0), .jobs1(jobs1), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4*W-1:0] matvec(input logic [16*W-1:0] m, input logic [4*W-1:0] v);
    logic [4*W-1:0] r;
    logic [W-1:0]   acc;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      acc = '0;
      for (int j = 0; j < 4; j++)
        acc = acc + m[(15 - (i*4 + j))*W +: W] * v[(3 - j)*W +: W];
      r[(3 - i)*W +: W] = acc;
    end
    return r;
  endfunction

  function automatic logic [16*W-1:0] rand_mat();
    logic [16*W-1:0] r;
    for (int k = 0; k < 16; k++) r[k*W +: W] = W'($urandom_range(0, 1000));
    return r;
  endfunction

  function automatic logic [4*W-1:0] rand_vec();
    logic [4*W-1:0] r;
    for (int k = 0; k < 4; k++) r[k*W +: W] = W'($urandom_range(0, 1000));
    return r;
  endfunction

  // Called just after a rising edge; the request is held until the acceptor drops it.
  task automatic send(input int n, input logic [16*W-1:0] m, input logic [4*W-1:0] v);
    if (n == 0) begin
      r0_mat = m; r0_vec = v; r0_valid = 1'b1; exp0.push_back(matvec(m, v));
    end else begin
      r1_mat = m; r1_vec = v; r1_valid = 1'b1; exp1.push_back(matvec(m, v));
    end
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while ((busy || r0_valid || r1_valid) && k < 400) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= 400) begin
      errors++;
      $display("FAIL %s_idle_wait: busy=%0b after %0d cycles, required 0", tag, busy, k);
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1; r0_valid = 1'b0; r1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp0.delete(); exp1.delete(); acc_q.delete();
  endtask

  // Requester side: drop valid once the accept edge has passed and log grant order.
  initial begin
    bit a0, a1;
    forever begin
      @(negedge clk);
      a0 = r0_valid && r0_ready;
      a1 = r1_valid && r1_ready;
      if (a0 || a1) begin
        @(posedge clk); #1;
        if (a0) begin r0_valid = 1'b0; acc_q.push_back(0); end
        if (a1) begin r1_valid = 1'b0; acc_q.push_back(1); end
      end
    end
  end

  // Behavioural matrix-vector unit with programmable accept stall and result latency.
  initial begin
    int g;
    mv_i_ready = 1'b0; mv_o_valid = 1'b0; mv_prod = '0;
    forever begin
      @(negedge clk);
      if (mv_i_valid) begin
        repeat (u_stall) @(negedge clk);
        mv_prod = matvec(mv_mat, mv_vec);
        mv_i_ready = 1'b1;
        @(negedge clk);
        mv_i_ready = 1'b0;
        if (!u_silent) begin
          repeat (u_lat - 1) @(negedge clk);
          mv_o_valid = 1'b1;
          g = 0;
          while (!mv_o_ready && g < 8) begin @(negedge clk); g++; end
          @(negedge clk);
          mv_o_valid = 1'b0;
        end
      end
    end
  end

  // Result monitor: each handshake pops the owner's scoreboard queue.
  initial begin
    logic [4*W-1:0] e;
    forever begin
      @(negedge clk);
      if (r0_res_valid && r1_res_valid) begin
        checks++; errors++;
        $display("FAIL both_res_valid: r0=%0b r1=%0b, required at most one", r0_res_valid, r1_res_valid);
      end
      if (r0_res_valid && r0_res_ready) begin
        checks++;
        if (exp0.size() == 0) begin
          errors++; $display("FAIL r0_unexpected_result: got %0h, required none", r0_res);
        end else begin
          e = exp0.pop_front();
          if (r0_res !== e || owner !== 1'b0) begin
            errors++; $display("FAIL r0_result: got %0h owner %0b, required %0h owner 0", r0_res, owner, e);
          end
        end
      end
      if (r1_res_valid && r1_res_ready) begin
        checks++;
        if (exp1.size() == 0) begin
          errors++; $display("FAIL r1_unexpected_result: got %0h, required none", r1_res);
        end else begin
          e = exp1.pop_front();
          if (r1_res !== e || owner !== 1'b1) begin
            errors++; $display("FAIL r1_result: got %0h owner %0b, required %0h owner 1", r1_res, owner, e);
          end
        end
      end
    end
  end

  task automatic test_reset();
    logic [10:0] flags;
    rst = 1'b1; r0_valid = 1'b1; r1_valid = 1'b0;
    r0_mat = rand_mat(); r0_vec = rand_vec(); r1_mat = '0; r1_vec = '0;
    r0_res_ready = 1'b1; r1_res_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (r0_ready !== 1'b0) begin
      errors++; $display("FAIL ready_in_reset: got %0b, required 0", r0_ready);
    end
    @(posedge clk); #1 r0_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    flags = {r0_ready, r1_ready, mv_i_valid, mv_o_ready, r0_res_valid, r1_res_valid,
             busy, owner, timeout_err, 2'b00};
    checks++;
    if (flags !== 11'd0) begin
      errors++; $display("FAIL reset_flags: got %b, required 00000000000", flags);
    end
    checks++;
    if (jobs0 !== 8'd0 || jobs1 !== 8'd0) begin
      errors++; $display("FAIL reset_jobs: got %0d/%0d, required 0/0", jobs0, jobs1);
    end
    checks++;
    if (mv_mat !== '0 || mv_vec !== '0 || r0_res !== '0) begin
      errors++; $display("FAIL reset_regs: mat %0h vec %0h res %0h, required 0", mv_mat, mv_vec, r0_res);
    end
  endtask

  task automatic test_single();
    logic [16*W-1:0] m;
    logic [4*W-1:0]  v;
    m = '0;
    for (int i = 0; i < 4; i++) m[(15 - i*5)*W +: W] = W'(1);
    v = {W'(1), W'(2), W'(3), W'(4)};
    @(posedge clk); #1;
    r0_mat = m; r0_vec = v; r0_valid = 1'b1; exp0.push_back(v);
    @(negedge clk);
    checks++;
    if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
      errors++; $display("FAIL single_grant: r0_ready %0b r1_ready %0b, required 1/0", r0_ready, r1_ready);
    end
    @(negedge clk);
    checks++;
    if (mv_i_valid !== 1'b1 || busy !== 1'b1 || owner !== 1'b0 || mv_vec !== v) begin
      errors++; $display("FAIL single_issue_latency: mv_i_valid %0b busy %0b owner %0b vec %0h, required 1 1 0 %0h",
                         mv_i_valid, busy, owner, mv_vec, v);
    end
    wait_idle("single");
    checks++;
    if (jobs0 !== 8'd1 || jobs1 !== 8'd0 || owner !== 1'b0 || exp0.size() != 0) begin
      errors++; $display("FAIL single_done: jobs %0d/%0d owner %0b pending %0d, required 1/0 0 0",
                         jobs0, jobs1, owner, exp0.size());
    end
  endtask

  task automatic test_arbitration();
    int order[7] = '{0, 1, 0, 1, 0, 1, 0};
    apply_reset();
    @(posedge clk); #1 send(0, rand_mat(), rand_vec()); send(1, rand_mat(), rand_vec());
    wait_idle("arb_pair1");
    @(posedge clk); #1 send(0, rand_mat(), rand_vec()); send(1, rand_mat(), rand_vec());
    wait_idle("arb_pair2");
    @(posedge clk); #1 send(0, rand_mat(), rand_vec());
    wait_idle("arb_single");
    @(posedge clk); #1 send(0, rand_mat(), rand_vec()); send(1, rand_mat(), rand_vec());
    wait_idle("arb_pair3");
    checks++;
    if (acc_q.size() != 7) begin
      errors++; $display("FAIL arb_grant_count: got %0d, required 7", acc_q.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        checks++;
        if (acc_q[i] != order[i]) begin
          errors++; $display("FAIL arb_order_%0d: got r%0d, required r%0d", i, acc_q[i], order[i]);
        end
      end
    end
    checks++;
    if (jobs0 !== 8'd4 || jobs1 !== 8'd3) begin
      errors++; $display("FAIL arb_jobs: got %0d/%0d, required 4/3", jobs0, jobs1);
    end
  endtask

  task automatic test_issue_stall();
    logic [16*W-1:0] m;
    logic [4*W-1:0]  v;
    apply_reset();
    m = rand_mat(); v = rand_vec();
    u_stall = 5;
    @(posedge clk); #1 send(0, m, v);
    @(negedge clk);
    @(posedge clk); #1 send(1, rand_mat(), rand_vec());
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (mv_i_valid !== 1'b1 || mv_mat !== m || mv_vec !== v || r0_ready !== 1'b0 || r1_ready !== 1'b0) begin
        errors++; $display("FAIL stall_hold_%0d: valid %0b rdy %0b%0b opnd_ok %0b, required 1 00 1",
                           c, mv_i_valid, r0_ready, r1_ready, (mv_mat === m && mv_vec === v));
      end
    end
    wait_idle("stall");
    u_stall = 0;
    checks++;
    if (jobs0 !== 8'd1 || jobs1 !== 8'd1) begin
      errors++; $display("FAIL stall_jobs: got %0d/%0d, required 1/1", jobs0, jobs1);
    end
  endtask

  task automatic test_result_stall();
    logic [16*W-1:0] m;
    logic [4*W-1:0]  v, ev;
    int k;
    apply_reset();
    m = rand_mat(); v = rand_vec(); ev = matvec(m, v);
    r1_res_ready = 1'b0;
    @(posedge clk); #1 send(1, m, v);
    k = 0;
    @(negedge clk);
    while (r1_res_valid !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    checks++;
    if (k >= 100) begin
      errors++; $display("FAIL ret_wait: r1_res_valid %0b after %0d cycles, required 1", r1_res_valid, k);
    end
    @(posedge clk); #1 send(0, rand_mat(), rand_vec());
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (r1_res_valid !== 1'b1 || r1_res !== ev || r0_ready !== 1'b0 || r0_res_valid !== 1'b0) begin
        errors++; $display("FAIL ret_hold_%0d: r1v %0b res %0h r0rdy %0b r0v %0b, required 1 %0h 0 0",
                           c, r1_res_valid, r1_res, r0_ready, r0_res_valid, ev);
      end
    end
    @(posedge clk); #1 r1_res_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (r0_ready !== 1'b0) begin
      errors++; $display("FAIL ret_no_bypass: r0_ready %0b during return handshake, required 0", r0_ready);
    end
    wait_idle("ret");
    checks++;
    if (jobs0 !== 8'd1 || jobs1 !== 8'd1 || acc_q.size() != 2 || acc_q[0] != 1) begin
      errors++; $display("FAIL ret_done: jobs %0d/%0d grants %0d, required 1/1 2 (r1 first)",
                         jobs0, jobs1, acc_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int k;
    bit seen;
    apply_reset();
    u_lat = 8;
    @(posedge clk); #1 send(0, rand_mat(), rand_vec());
    k = 0;
    @(negedge clk);
    while (mv_o_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    checks++;
    if (k >= 50) begin
      errors++; $display("FAIL rstmid_wait: mv_o_ready %0b, required 1", mv_o_ready);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy, mv_o_ready, mv_i_valid, r0_res_valid, r1_res_valid, owner, r0_ready} !== 7'd0
        || jobs0 !== 8'd0) begin
      errors++; $display("FAIL rstmid_outputs: busy %0b mv_o_ready %0b res_v %0b jobs0 %0d, required all 0",
                         busy, mv_o_ready, r0_res_valid, jobs0);
    end
    rst = 1'b0;
    exp0.delete();
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (r0_res_valid || r1_res_valid || busy) seen = 1'b1;
    end
    checks++;
    if (seen || jobs0 !== 8'd0) begin
      errors++; $display("FAIL rstmid_late_result: activity %0b jobs0 %0d, required 0 0", seen, jobs0);
    end
    u_lat = 3;
  endtask

`ifdef MVP_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int k;
    apply_reset();
    u_silent = 1'b1;
    @(posedge clk); #1 send(0, rand_mat(), rand_vec());
    k = 0;
    @(negedge clk);
    while (mv_i_valid !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    repeat (TO - 1) @(negedge clk);
    checks++;
    if (timeout_err !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL to_early: err %0b busy %0b at cycle %0d, required 0 1", timeout_err, busy, TO - 1);
    end
    @(negedge clk);
    checks++;
    if (timeout_err !== 1'b1 || busy !== 1'b0 || jobs0 !== 8'd0 || r0_res_valid !== 1'b0) begin
      errors++; $display("FAIL to_fire: err %0b busy %0b jobs0 %0d, required 1 0 0", timeout_err, busy, jobs0);
    end
    exp0.delete();
    u_silent = 1'b0;
    @(posedge clk); #1 send(0, rand_mat(), rand_vec());
    wait_idle("to_next");
    checks++;
    if (timeout_err !== 1'b1 || jobs0 !== 8'd1) begin
      errors++; $display("FAIL to_sticky: err %0b jobs0 %0d, required 1 1", timeout_err, jobs0);
    end
    apply_reset();
    @(negedge clk);
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++; $display("FAIL to_clear: err %0b, required 0", timeout_err);
    end
  endtask
`endif

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_arbitration();
    test_issue_stall();
    test_result_stall();
    test_reset_mid();
`ifdef MVP_ARB_TIMEOUT_EN
    test_timeout();
`endif
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
